// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg: shared encodings and types for the pipeline hazard
// scheduler.
//   - TUSE_NONE      : Tuse value meaning "operand not read"
//   - FWD_D_* / FWD_E_* / FWD_M_* : forwarding-source mux encodings
//   - stage_rec_t    : per-stage {dst, tnew, rs, rt} record
//   - md_state_t     : MDU sequencer states
//   - tnew_dec       : saturating Tnew decrement applied on each advance
package hazard_sched_pkg;

  localparam logic [1:0] TUSE_NONE   = 2'd3;

  localparam logic [1:0] FWD_D_GRF   = 2'd0;
  localparam logic [1:0] FWD_D_E     = 2'd1;
  localparam logic [1:0] FWD_D_M     = 2'd2;

  localparam logic [1:0] FWD_E_LATCH = 2'd0;
  localparam logic [1:0] FWD_E_M     = 2'd1;
  localparam logic [1:0] FWD_E_W     = 2'd2;

  localparam logic [1:0] FWD_M_LATCH = 2'd0;
  localparam logic [1:0] FWD_M_W     = 2'd2;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_sched_md_busy_ctr.sv
// md_busy_ctr: multiply/divide busy-window sequencer. A down-counter that
// loads the operation latency on start and counts to zero.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : an MDU operation leaves D this cycle
//   start_div    : qualifies start (1 = div, 0 = mult)
//   busy         : MDU result still pending
//
// state   | meaning
// --------+------------------------------------------
// MD_IDLE | cnt == 0, HI/LO are final
// MD_BUSY | cnt  > 0, mult/div still computing
module md_busy_ctr
  import hazard_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic start_div,
  output logic busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_t       state, state_next;
  logic [CW-1:0]   cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    if (start) begin
      cnt_next = start_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (state == MD_BUSY) begin
      cnt_next = cnt - CW'(1);
    end
    // State tracks the terminal-count compare so it never disagrees with cnt.
    state_next = (cnt_next != '0) ? MD_BUSY : MD_IDLE;
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: D-stage stall and operand-forwarding control for the
// five-stage core, plus the MDU busy window.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   d_rs, d_rt               : D-stage source register indices
//   d_tuse_rs, d_tuse_rt     : stage offset at which each source is read (3 = unused)
//   d_dst, d_tnew            : D destination (0 = none) and Tnew measured in E
//   d_md_start, d_md_div     : D instruction starts mult (0) / div (1)
//   d_md_use                 : D instruction touches HI/LO/MDU
//   stall                    : freeze PC and F/D, bubble into D/E
//   fwd_rs_d, fwd_rt_d       : D operand source (GRF / E / M)
//   fwd_rs_e, fwd_rt_e       : E operand source (latched / M / W)
//   fwd_rt_m                 : M store-data source (latched / W)
//   md_busy                  : MDU result pending
// W-stage results reach D through the register file write-through, so there
// is no W->D select.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [1:0] fwd_rt_m,
  output logic       md_busy
);

  // M keeps only the fields something still reads (dst, tnew, store-data rt);
  // W only needs dst because its Tnew is always 0 and its sources are spent.
  stage_rec_t rec_d;
  stage_rec_t rec_e;
  logic [4:0] m_dst;
  logic [1:0] m_tnew;
  logic [4:0] m_rt;
  logic [4:0] w_dst;

  logic hz_rs, hz_rt, md_start;

  function automatic logic raw_hazard(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] e_dst_i,
    input logic [1:0] e_tnew_i,
    input logic [4:0] m_dst_i,
    input logic [1:0] m_tnew_i
  );
    return (r != 5'd0) && (tuse != TUSE_NONE) &&
           (((e_dst_i == r) && (tuse < e_tnew_i)) ||
            ((m_dst_i == r) && (tuse < m_tnew_i)));
  endfunction

  // Nearest producer wins; a producer only forwards once its Tnew hits 0.
  function automatic logic [1:0] sel_d(
    input logic [4:0] r,
    input logic [4:0] e_dst_i,
    input logic [1:0] e_tnew_i,
    input logic [4:0] m_dst_i,
    input logic [1:0] m_tnew_i
  );
    if (r == 5'd0)                                  return FWD_D_GRF;
    else if ((e_dst_i == r) && (e_tnew_i == 2'd0))  return FWD_D_E;
    else if ((m_dst_i == r) && (m_tnew_i == 2'd0))  return FWD_D_M;
    else                                            return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] sel_e(
    input logic [4:0] r,
    input logic [4:0] m_dst_i,
    input logic [1:0] m_tnew_i,
    input logic [4:0] w_dst_i
  );
    if (r == 5'd0)                                  return FWD_E_LATCH;
    else if ((m_dst_i == r) && (m_tnew_i == 2'd0))  return FWD_E_M;
    else if (w_dst_i == r)                          return FWD_E_W;
    else                                            return FWD_E_LATCH;
  endfunction

  always_comb begin
    rec_d      = REC_BUBBLE;
    rec_d.dst  = d_dst;
    rec_d.tnew = d_tnew;
    rec_d.rs   = d_rs;
    rec_d.rt   = d_rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_e  <= REC_BUBBLE;
      m_dst  <= '0;
      m_tnew <= '0;
      m_rt   <= '0;
      w_dst  <= '0;
    end else begin
      w_dst  <= m_dst;
      m_dst  <= rec_e.dst;
      m_tnew <= tnew_dec(rec_e.tnew);
      m_rt   <= rec_e.rt;
      rec_e  <= stall ? REC_BUBBLE : rec_d;
    end
  end

  always_comb begin
    hz_rs    = raw_hazard(d_rs, d_tuse_rs, rec_e.dst, rec_e.tnew, m_dst, m_tnew);
    hz_rt    = raw_hazard(d_rt, d_tuse_rt, rec_e.dst, rec_e.tnew, m_dst, m_tnew);
    stall    = hz_rs | hz_rt | (d_md_use & md_busy);

    fwd_rs_d = sel_d(d_rs, rec_e.dst, rec_e.tnew, m_dst, m_tnew);
    fwd_rt_d = sel_d(d_rt, rec_e.dst, rec_e.tnew, m_dst, m_tnew);
    fwd_rs_e = sel_e(rec_e.rs, m_dst, m_tnew, w_dst);
    fwd_rt_e = sel_e(rec_e.rt, m_dst, m_tnew, w_dst);
    fwd_rt_m = ((m_rt != 5'd0) && (w_dst == m_rt)) ? FWD_M_W : FWD_M_LATCH;
  end

  // A start only counts when the instruction actually leaves D.
  assign md_start = d_md_start & ~stall;

  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .start_div (d_md_div),
    .busy      (md_busy)
  );

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed scenarios plus randomized traffic against a
// reference model that tracks in-flight instructions by age and the MDU by
// the absolute cycle at which its result becomes final.
module tb_hazard_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  always #5 clk = ~clk;

  hazard_sched #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .fwd_rt_m   (fwd_rt_m),
    .md_busy    (md_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: slot 0 = E, 1 = M, 2 = W. q_tnew holds Tnew as it was on entry to
  // E; the current value is derived from the slot's age.
  int         cyc = 0;
  int         md_until = 0;
  logic [4:0] q_dst [3];
  logic [4:0] q_rs  [3];
  logic [4:0] q_rt  [3];
  int         q_tnew[3];

  logic       obs_stall, obs_busy;
  logic [1:0] obs_rs_d, obs_rt_d, obs_rs_e, obs_rt_e, obs_rt_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int tn(input int k);
    int t;
    t = q_tnew[k] - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic logic m_hazard(input logic [4:0] r, input logic [1:0] tu);
    if (r == 0 || tu == 2'd3) return 1'b0;
    return (q_dst[0] == r && int'(tu) < tn(0)) || (q_dst[1] == r && int'(tu) < tn(1));
  endfunction

  function automatic logic [1:0] m_fwd_d(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (q_dst[0] == r && tn(0) == 0) return 2'd1;
    if (q_dst[1] == r && tn(1) == 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (q_dst[1] == r && tn(1) == 0) return 2'd1;
    if (q_dst[2] == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      q_dst[k] = '0; q_rs[k] = '0; q_rt[k] = '0; q_tnew[k] = 0;
    end
    md_until = 0;
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                      input logic [4:0] dst, input logic [1:0] tnew,
                      input logic mds, input logic mdd, input logic mdu,
                      input logic rst);
    logic e_stall, e_busy;
    @(negedge clk);
    reset = rst; d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
    d_dst = dst; d_tnew = tnew; d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    #1;
    e_busy  = (cyc < md_until);
    e_stall = m_hazard(rs, tu_rs) | m_hazard(rt, tu_rt) | (mdu & e_busy);
    obs_stall = stall; obs_busy = md_busy;
    obs_rs_d = fwd_rs_d; obs_rt_d = fwd_rt_d;
    obs_rs_e = fwd_rs_e; obs_rt_e = fwd_rt_e; obs_rt_m = fwd_rt_m;
    check("stall",    obs_stall, e_stall);
    check("md_busy",  obs_busy,  e_busy);
    check("fwd_rs_d", obs_rs_d,  m_fwd_d(rs));
    check("fwd_rt_d", obs_rt_d,  m_fwd_d(rt));
    check("fwd_rs_e", obs_rs_e,  m_fwd_e(q_rs[0]));
    check("fwd_rt_e", obs_rt_e,  m_fwd_e(q_rt[0]));
    check("fwd_rt_m", obs_rt_m,  (q_rt[1] != 0 && q_dst[2] == q_rt[1]) ? 2'd2 : 2'd0);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      q_dst[2] = q_dst[1]; q_rs[2] = q_rs[1]; q_rt[2] = q_rt[1]; q_tnew[2] = q_tnew[1];
      q_dst[1] = q_dst[0]; q_rs[1] = q_rs[0]; q_rt[1] = q_rt[0]; q_tnew[1] = q_tnew[0];
      if (e_stall) begin
        q_dst[0] = '0; q_rs[0] = '0; q_rt[0] = '0; q_tnew[0] = 0;
      end else begin
        q_dst[0] = dst; q_rs[0] = rs; q_rt[0] = rt; q_tnew[0] = int'(tnew);
        if (mds) md_until = cyc + 1 + (mdd ? DIV_N : MULT_N);
      end
    end
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_dst = '0; d_tnew = '0; d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);

    // first cycle after reset
    nop(1);
    check("rst_stall", obs_stall, 0);
    check("rst_busy",  obs_busy,  0);
    check("rst_fwd",   {obs_rs_d, obs_rt_d, obs_rs_e, obs_rt_e, obs_rt_m}, 0);

    // add $1 then dependent sub in E
    step(0, 0, 3, 3, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 4, 1, 0, 0, 0, 0);
    check("alu_alu_stall", obs_stall, 0);
    nop(1);
    check("alu_alu_fwd_rs_e", obs_rs_e, 1);
    nop(3);

    // lw $2 then dependent add: one bubble, then the load reaches add via W
    step(0, 0, 3, 3, 2, 2, 0, 0, 0, 0);
    step(2, 0, 1, 3, 5, 1, 0, 0, 0, 0);
    check("lw_add_stall1", obs_stall, 1);
    step(2, 0, 1, 3, 5, 1, 0, 0, 0, 0);
    check("lw_add_release", obs_stall, 0);
    nop(1);
    check("lw_add_fwd_rs_e", obs_rs_e, 2);
    nop(3);

    // lw $3 then beq $3: two bubbles, then GRF write-through
    step(0, 0, 3, 3, 3, 2, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(3, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      if (obs_stall) n++; else break;
    end
    check("lw_beq_stall_len", n, 2);
    check("lw_beq_fwd_rs_d", obs_rs_d, 0);
    nop(3);

    // jal then jr $31
    step(0, 0, 3, 3, 31, 0, 0, 0, 0, 0);
    step(31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    check("jal_jr_stall", obs_stall, 0);
    check("jal_jr_fwd_rs_d", obs_rs_d, 1);
    nop(3);

    // mult then mflo, div then mfhi
    step(1, 2, 1, 1, 0, 0, 1, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 3, 3, 8, 1, 0, 0, 1, 0);
      if (obs_stall) n++; else break;
    end
    check("mult_mflo_stall_len", n, MULT_N);
    check("mult_release_busy", obs_busy, 0);
    nop(3);
    step(1, 2, 1, 1, 0, 0, 1, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 3, 3, 9, 1, 0, 0, 1, 0);
      if (obs_stall) n++; else break;
    end
    check("div_mfhi_stall_len", n, DIV_N);
    check("div_release_busy", obs_busy, 0);
    nop(3);

    // reset while busy
    step(1, 2, 1, 1, 0, 0, 1, 1, 1, 0);
    step(0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
    step(0, 0, 3, 3, 8, 1, 0, 0, 1, 0);
    check("rst_busy_stall", obs_stall, 0);
    check("rst_busy_busy",  obs_busy,  0);
    nop(2);

    // register 0 never creates a hazard
    step(0, 0, 3, 3, 0, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    check("r0_stall", obs_stall, 0);
    check("r0_fwd_rs_d", obs_rs_d, 0);
    nop(3);

    // randomized traffic over a small register window
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rs, rt, dst;
      logic [1:0] tu_rs, tu_rt, tnew;
      logic mdu, mds, mdd, rst;
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      dst   = 5'($urandom_range(0, 3));
      tu_rs = 2'($urandom_range(0, 3));
      tu_rt = 2'($urandom_range(0, 3));
      tnew  = 2'($urandom_range(0, 2));
      mdu   = ($urandom_range(0, 5) == 0);
      mds   = mdu & 1'($urandom_range(0, 1));
      mdd   = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 199) == 0);
      step(rs, rt, tu_rs, tu_rt, dst, tnew, mds, mdd, mdu, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
